// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory port arbiter.
//   arb_state_t      : arbiter FSM states (IDLE -> ACCESS -> RESP -> IDLE)
//   port_id_t        : requester index (0 = core load/store, 1 = loader/debug)
//   WORD_ALIGN_MASK  : low address bits that must be zero for a word access
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } arb_state_t;

  typedef logic port_id_t;

  localparam logic [1:0] WORD_ALIGN_MASK = 2'b11;

endpackage

// File: rtl/dmem_port_arbiter_if.sv
// One requester channel into the data-memory port arbiter.
//   valid/ready       : request handshake, accepted when both are high at posedge
//   we/addr/wdata     : request payload, held stable by the requester until accepted
//   rsp_valid         : one-cycle response pulse
//   rsp_rdata/rsp_err : response payload, meaningful while rsp_valid is high
// Modports:
//   master : requester side
//   slave  : arbiter side
interface dmem_port_arbiter_if #(
  parameter int unsigned W = 32
);

  logic         valid;
  logic         ready;
  logic         we;
  logic [W-1:0] addr;
  logic [W-1:0] wdata;
  logic         rsp_valid;
  logic [W-1:0] rsp_rdata;
  logic         rsp_err;

  modport master (
    output valid, we, addr, wdata,
    input  ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  valid, we, addr, wdata,
    output ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/dmem_arb_pick.sv
// Combinational grant selection for the two requester ports.
//   valid[1:0]  in   pending requests, bit X = port X
//   last_grant  in   port that won the most recent accept
//   grant[1:0]  out  one-hot winner, or 0 when nothing is pending
// Policy is chosen at build time:
//   DMEM_ARB_ROUND_ROBIN_EN defined   : on a tie, grant the port != last_grant
//   DMEM_ARB_ROUND_ROBIN_EN undefined : fixed priority, port 0 wins every tie
module dmem_arb_pick
  import dmem_arb_pkg::*;
(
  input  logic [1:0] valid,
  input  port_id_t   last_grant,
  output logic [1:0] grant
);

`ifndef DMEM_ARB_ROUND_ROBIN_EN
  // Fixed priority never looks at the grant history.
  logic unused_last_grant;
  assign unused_last_grant = last_grant;
`endif

  always_comb begin
    grant = '0;
    unique case (valid)
      2'b01: grant = 2'b01;
      2'b10: grant = 2'b10;
      2'b11: begin
`ifdef DMEM_ARB_ROUND_ROBIN_EN
        grant = (last_grant == 1'b1) ? 2'b01 : 2'b10;
`else
        grant = 2'b01;
`endif
      end
      default: grant = '0;
    endcase
  end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares the single-port data_memory between port 0 (core load/store) and
// port 1 (loader/debug). One transaction takes three cycles:
//   IDLE   : pick a winner, raise only its ready, latch its request on accept
//   ACCESS : drive the memory for one cycle; write and read capture at the closing edge
//   RESP   : pulse the winner's rsp_valid with read data (0 on write/error) and err
// Ports:
//   clk, rst        : clock and asynchronous active-low reset
//   req0, req1      : requester channels (slave side of dmem_port_arbiter_if)
//   mem_*           : data_memory control / data (combinational read data in)
//   busy            : high whenever the FSM is not in IDLE
// Build option: DMEM_ARB_ROUND_ROBIN_EN selects round-robin tie breaking
// (handled inside dmem_arb_pick); default is fixed priority to port 0.
module dmem_port_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned W = 32,
  parameter int unsigned N = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  dmem_port_arbiter_if.slave   req0,
  dmem_port_arbiter_if.slave   req1,
  output logic [W-1:0]         mem_address,
  output logic                 mem_MemRead,
  output logic                 mem_MemWrite,
  output logic [W-1:0]         mem_write_data,
  input  logic [W-1:0]         mem_read_data,
  output logic                 busy
);

  arb_state_t   state_q, state_d;
  logic [W-1:0] addr_q, wdata_q, rdata_q;
  logic         we_q, err_q;
  port_id_t     owner_q, last_grant_q;

  logic [1:0]   grant;
  logic         accept;
  port_id_t     sel_port;
  logic [W-1:0] sel_addr, sel_wdata;
  logic         sel_we, sel_err;

  logic [1:0]   ready_vec;
  logic [1:0]   rsp_vld;
  logic [W-1:0] rsp_data;

  dmem_arb_pick u_pick (
    .valid      ({req1.valid, req0.valid}),
    .last_grant (last_grant_q),
    .grant      (grant)
  );

  assign accept    = (state_q == IDLE) && (grant != 2'b00);
  assign sel_port  = grant[1];
  assign sel_addr  = sel_port ? req1.addr  : req0.addr;
  assign sel_wdata = sel_port ? req1.wdata : req0.wdata;
  assign sel_we    = sel_port ? req1.we    : req0.we;
  // Misaligned, or at/above the 2**N byte span.
  assign sel_err   = ((sel_addr[1:0] & WORD_ALIGN_MASK) != 2'b00) || (|sel_addr[W-1:N]);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      we_q         <= 1'b0;
      err_q        <= 1'b0;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q       <= sel_addr;
        wdata_q      <= sel_wdata;
        we_q         <= sel_we;
        err_q        <= sel_err;
        owner_q      <= sel_port;
        last_grant_q <= sel_port;
      end
      if (state_q == ACCESS) begin
        rdata_q <= (we_q || err_q) ? '0 : mem_read_data;
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    ready_vec      = '0;
    rsp_vld        = '0;
    rsp_data       = '0;
    mem_address    = '0;
    mem_write_data = '0;
    mem_MemRead    = 1'b0;
    mem_MemWrite   = 1'b0;
    unique case (state_q)
      IDLE: begin
        // ready is combinational from valid, so hold it low while reset is asserted.
        if (rst) ready_vec = grant;
        if (accept) state_d = ACCESS;
      end
      ACCESS: begin
        mem_address    = addr_q;
        mem_write_data = wdata_q;
        mem_MemWrite   = we_q & ~err_q;
        mem_MemRead    = ~we_q & ~err_q;
        state_d        = RESP;
      end
      RESP: begin
        rsp_vld[owner_q] = 1'b1;
        rsp_data         = rdata_q;
        state_d          = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);

  assign req0.ready     = ready_vec[0];
  assign req1.ready     = ready_vec[1];
  assign req0.rsp_valid = rsp_vld[0];
  assign req1.rsp_valid = rsp_vld[1];
  assign req0.rsp_rdata = rsp_vld[0] ? rsp_data : '0;
  assign req1.rsp_rdata = rsp_vld[1] ? rsp_data : '0;
  assign req0.rsp_err   = rsp_vld[0] & err_q;
  assign req1.rsp_err   = rsp_vld[1] & err_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Self-checking bench for dmem_port_arbiter with a behavioural 8-word data_memory.
// Expected responses are queued per port at accept time; a monitor on the
// falling edge pops and compares whenever a response pulse appears.
module tb_dmem_port_arbiter;

  localparam int unsigned W = 32;
  localparam int unsigned N = 5;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc_pre;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [W-1:0] mem_address, mem_write_data, mem_read_data;
  logic         mem_MemRead, mem_MemWrite, busy;

  logic [31:0]  mem [0:7];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int wr_cnt = 0;
  int rd_cnt = 0;
  int bad_ready = 0;

  exp_t exp_q0[$];
  exp_t exp_q1[$];
  exp_t mon_e;
  int   grant_log[$];

`ifdef DMEM_ARB_ROUND_ROBIN_EN
  int exp_grants[4] = '{0, 1, 0, 1};
`else
  int exp_grants[4] = '{0, 0, 0, 0};
`endif

  dmem_port_arbiter_if #(.W(W)) req0_if ();
  dmem_port_arbiter_if #(.W(W)) req1_if ();

  dmem_port_arbiter #(.W(W), .N(N)) dut (
    .clk            (clk),
    .rst            (rst),
    .req0           (req0_if),
    .req1           (req1_if),
    .mem_address    (mem_address),
    .mem_MemRead    (mem_MemRead),
    .mem_MemWrite   (mem_MemWrite),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // data_memory: combinational read, write at posedge.
  assign mem_read_data = mem[mem_address[4:2]];
  always @(posedge clk) begin
    if (mem_MemWrite) mem[mem_address[4:2]] = mem_write_data;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (time %0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (mem_MemWrite) wr_cnt++;
    if (mem_MemRead) rd_cnt++;
    if (busy && (req0_if.ready || req1_if.ready)) bad_ready++;
    if (req0_if.rsp_valid) begin
      if (exp_q0.size() == 0) check("rsp0_unexpected", 1, 0);
      else begin
        mon_e = exp_q0.pop_front();
        check("rsp0_rdata", req0_if.rsp_rdata, mon_e.rdata);
        check("rsp0_err", req0_if.rsp_err, mon_e.err);
        check("rsp0_latency", cyc, mon_e.acc_pre + 2);
      end
    end
    if (req1_if.rsp_valid) begin
      if (exp_q1.size() == 0) check("rsp1_unexpected", 1, 0);
      else begin
        mon_e = exp_q1.pop_front();
        check("rsp1_rdata", req1_if.rsp_rdata, mon_e.rdata);
        check("rsp1_err", req1_if.rsp_err, mon_e.err);
        check("rsp1_latency", cyc, mon_e.acc_pre + 2);
      end
    end
  end

  // Present a request on port p and hold it until accepted. valid is left high
  // afterwards; the caller (or the next send) decides what happens next.
  task automatic send(input int p, input logic we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [31:0] exp_rdata,
                      input logic exp_err, input bit expect_rsp, output int acc_pre);
    bit   acc;
    exp_t e;
    acc     = 1'b0;
    acc_pre = -1;
    @(negedge clk);
    if (p == 0) begin
      req0_if.valid = 1'b1; req0_if.we = we; req0_if.addr = addr; req0_if.wdata = wdata;
    end else begin
      req1_if.valid = 1'b1; req1_if.we = we; req1_if.addr = addr; req1_if.wdata = wdata;
    end
    for (int k = 0; k < 100; k++) begin
      #1;
      acc = (p == 0) ? req0_if.ready : req1_if.ready;
      if (acc) acc_pre = cyc;
      @(posedge clk);
      if (acc) break;
      @(negedge clk);
    end
    if (!acc) check("accept_timeout", 0, 1);
    else begin
      grant_log.push_back(p);
      if (expect_rsp) begin
        e.rdata   = exp_rdata;
        e.err     = exp_err;
        e.acc_pre = acc_pre;
        if (p == 0) exp_q0.push_back(e);
        else        exp_q1.push_back(e);
      end
    end
  endtask

  task automatic release_port(input int p);
    @(negedge clk);
    if (p == 0) req0_if.valid = 1'b0;
    else        req1_if.valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (!busy && exp_q0.size() == 0 && exp_q1.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) check("idle_timeout", 0, 1);
    @(negedge clk);
  endtask

  int a0, a1, t0, t1, wr0, rd0, br0;

  initial begin
    for (int i = 0; i < 8; i++) mem[i] = 32'h1000_0000 + i;
    req0_if.valid = 1'b0; req0_if.we = 1'b0; req0_if.addr = '0; req0_if.wdata = '0;
    req1_if.valid = 1'b0; req1_if.we = 1'b0; req1_if.addr = '0; req1_if.wdata = '0;

    // Reset held with a pending port 0 request.
    req0_if.valid = 1'b1;
    req0_if.addr  = 32'h08;
    repeat (3) @(negedge clk);
    #1;
    check("reset_ready0", req0_if.ready, 0);
    check("reset_ready1", req1_if.ready, 0);
    check("reset_rsp0", req0_if.rsp_valid, 0);
    check("reset_memread", mem_MemRead, 0);
    check("reset_memwrite", mem_MemWrite, 0);
    check("reset_busy", busy, 0);
    req0_if.valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Port 0 write then read-back.
    wr0 = wr_cnt;
    send(0, 1'b1, 32'h08, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b1, a0);
    release_port(0);
    wait_idle();
    check("write_memwrite_cycles", wr_cnt - wr0, 1);
    send(0, 1'b0, 32'h08, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b1, a0);
    release_port(0);
    wait_idle();

    // Both ports valid continuously.
    grant_log.delete();
    fork
      begin
        for (int i = 0; i < 4; i++) send(0, 1'b0, 32'h04, 32'h0, 32'h1000_0001, 1'b0, 1'b1, t0);
        release_port(0);
      end
      begin
        for (int i = 0; i < 4; i++) send(1, 1'b0, 32'h0C, 32'h0, 32'h1000_0003, 1'b0, 1'b1, t1);
        release_port(1);
      end
    join
    wait_idle();
    check("tie_log_size", grant_log.size(), 8);
    for (int i = 0; i < 4; i++) begin
      if (grant_log.size() > i) check($sformatf("tie_grant%0d", i), grant_log[i], exp_grants[i]);
    end

    // Error accesses on port 1: misaligned and out of range.
    wr0 = wr_cnt;
    rd0 = rd_cnt;
    send(1, 1'b0, 32'h06, 32'h0, 32'h0, 1'b1, 1'b1, a1);
    release_port(1);
    wait_idle();
    send(1, 1'b0, 32'h20, 32'h0, 32'h0, 1'b1, 1'b1, a1);
    release_port(1);
    wait_idle();
    check("err_no_memread", rd_cnt - rd0, 0);
    check("err_no_memwrite", wr_cnt - wr0, 0);

    // Reset asserted during ACCESS of a write: no write, no response.
    send(0, 1'b1, 32'h10, 32'h1234_5678, 32'h0, 1'b0, 1'b0, a0);
    @(negedge clk);
    req0_if.valid = 1'b0;
    #1;
    check("midrst_memwrite_before", mem_MemWrite, 1);
    rst = 1'b0;
    #1;
    check("midrst_memwrite_after", mem_MemWrite, 0);
    check("midrst_busy", busy, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    wait_idle();
    send(0, 1'b0, 32'h10, 32'h0, 32'h1000_0004, 1'b0, 1'b1, a0);
    release_port(0);
    wait_idle();

    // Port 1 arrives while port 0 is in flight.
    br0 = bad_ready;
    fork
      begin
        send(0, 1'b0, 32'h08, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b1, t0);
        release_port(0);
      end
      begin
        @(negedge clk);
        send(1, 1'b1, 32'h14, 32'hCAFE_F00D, 32'h0, 1'b0, 1'b1, t1);
        release_port(1);
      end
    join
    wait_idle();
    check("inflight_ready_while_busy", bad_ready - br0, 0);
    check("inflight_port1_first_idle", t1, t0 + 3);
    send(0, 1'b0, 32'h14, 32'h0, 32'hCAFE_F00D, 1'b0, 1'b1, a0);
    release_port(0);
    wait_idle();

    check("exp_q0_drained", exp_q0.size(), 0);
    check("exp_q1_drained", exp_q1.size(), 0);
    check("total_ready_while_busy", bad_ready, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
